// File: rtl/pos_read_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pos_read_sequencer_pkg : shared state encoding and address constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pos_read_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_NUM   = 3'd1,
    WAIT_CNT = 3'd2,
    SWEEP    = 3'd3,
    DRAIN    = 3'd4,
    FINISH   = 3'd5
  } seq_state_t;

  // Address 0 of the position cache holds the home-cell particle count.
  localparam int unsigned COUNT_SLOT_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/pos_read_sequencer_if.sv
// ----------------------------------------------------------------------------
// pos_read_sequencer_if : control/status bundle between PE control and sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pos_read_sequencer_if #(
  parameter int PARTICLE_ID_WIDTH = 7
) ();

  logic                         start;
  logic                         stall;
  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count;
  logic                         phase;
  logic                         reading_particle_num;
  logic                         pause_reading;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic [PARTICLE_ID_WIDTH-1:0] particle_id;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;

  modport master (
    output start, stall, ref_particle_count,
    input  phase, reading_particle_num, pause_reading,
           ref_id, particle_id, busy, done, cfg_err
  );

  modport slave (
    input  start, stall, ref_particle_count,
    output phase, reading_particle_num, pause_reading,
           ref_id, particle_id, busy, done, cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/pos_read_sequencer.sv
// ----------------------------------------------------------------------------
// pos_read_sequencer : sweeps all (ref_id, particle_id) pairs of one home cell
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pos_read_sequencer
  import pos_read_sequencer_pkg::*;
#(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int COUNT_WAIT_CYCLES = 2,
  parameter int DRAIN_CYCLES      = 3
) (
  input  logic                clk,
  input  logic                rst,
  pos_read_sequencer_if.slave bus
);

  localparam int W       = PARTICLE_ID_WIDTH;
  localparam int CNT_MAX = (COUNT_WAIT_CYCLES > DRAIN_CYCLES) ? COUNT_WAIT_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  localparam logic [W-1:0]     ID_ONE    = W'(1);
  localparam logic [W-1:0]     ID_SLOT   = W'(COUNT_SLOT_ADDR);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(COUNT_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic             phase_q, phase_d;
  logic             rpn_q, rpn_d;
  logic             pause_q, pause_d;
  logic [W-1:0]     ref_q, ref_d;
  logic [W-1:0]     pid_q, pid_d;
  logic [W-1:0]     n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rpn_d   = rpn_q;
    ref_d   = ref_q;
    pid_d   = pid_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD_NUM;
          rpn_d   = 1'b1;
          phase_d = 1'b0;
          ref_d   = ID_SLOT;
          pid_d   = ID_SLOT;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      // Phase doubles as the two-cycle count-slot read counter.
      RD_NUM: begin
        if (!pause_q) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            rpn_d   = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_CNT;
          end
        end
      end

      WAIT_CNT: begin
        if (cnt_q == WAIT_LAST) begin
          n_d   = bus.ref_particle_count;
          cnt_d = '0;
          if (bus.ref_particle_count == '0) begin
            ref_d   = ID_ONE;
            pid_d   = ID_ONE;
            state_d = DRAIN;
          end else if (&bus.ref_particle_count) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            ref_d   = ID_ONE;
            pid_d   = ID_ONE;
            phase_d = 1'b0;
            state_d = SWEEP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Ids advance only when leaving phase 1; the last pair parks on N+1.
      SWEEP: begin
        if (!pause_q) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pid_q == n_q) begin
              if (ref_q == n_q) begin
                ref_d   = n_q + ID_ONE;
                pid_d   = n_q + ID_ONE;
                cnt_d   = '0;
                state_d = DRAIN;
              end else begin
                pid_d = ID_ONE;
                ref_d = ref_q + ID_ONE;
              end
            end else begin
              pid_d = pid_q + ID_ONE;
            end
          end
        end
      end

      DRAIN: begin
        if (cnt_q == DRN_LAST) begin
          done_d  = 1'b1;
          ref_d   = ID_SLOT;
          pid_d   = ID_SLOT;
          phase_d = 1'b0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    pause_d = bus.stall && ((state_d == SWEEP) || (state_d == RD_NUM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      rpn_q   <= 1'b0;
      pause_q <= 1'b0;
      ref_q   <= '0;
      pid_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rpn_q   <= rpn_d;
      pause_q <= pause_d;
      ref_q   <= ref_d;
      pid_q   <= pid_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.phase                = phase_q;
  assign bus.reading_particle_num = rpn_q;
  assign bus.pause_reading        = pause_q;
  assign bus.ref_id               = ref_q;
  assign bus.particle_id          = pid_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.cfg_err              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pos_read_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pos_read_sequencer : scoreboard bench for the home-cell read sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pos_read_sequencer;

  localparam int W     = 7;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pos_read_sequencer_if #(.PARTICLE_ID_WIDTH(W)) bus ();

  pos_read_sequencer #(
    .PARTICLE_ID_WIDTH(W),
    .COUNT_WAIT_CYCLES(2),
    .DRAIN_CYCLES     (DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit is_done;
    int code;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic int code_of(int ph, int r, int p);
    return ph * 10000 + r * 100 + p;
  endfunction

  function automatic void chk(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endfunction

  // Each issued (phase, ref_id, particle_id) beat and each done pulse is
  // matched in order against the expected stream.
  always @(negedge clk) begin
    int act;
    if (!rst) begin
      if (bus.busy && !bus.pause_reading && bus.ref_id != '0) begin
        act = code_of(int'(bus.phase), int'(bus.ref_id), int'(bus.particle_id));
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          chk("stray_issue", act, 0);
        end else begin
          chk("issue", act, exp_q[0].code);
          exp_q.delete(0);
        end
      end
      if (bus.done) begin
        if (exp_q.size() != 0 && exp_q[0].is_done) begin
          chk("done_cfg_err", int'(bus.cfg_err), int'(exp_q[0].err));
          exp_q.delete(0);
        end else begin
          chk("stray_done", int'(bus.done), 0);
        end
      end
    end
  end

  task automatic push_model(input int n);
    exp_t e;
    bit   err;
    err = (n == (1 << W) - 1);
    e.is_done = 1'b0;
    e.err     = 1'b0;
    if (!err) begin
      for (int r = 1; r <= n; r++) begin
        for (int p = 1; p <= n; p++) begin
          e.code = code_of(0, r, p);
          exp_q.push_back(e);
          e.code = code_of(1, r, p);
          exp_q.push_back(e);
        end
      end
      for (int i = 0; i < DRAIN; i++) begin
        e.code = code_of(0, n + 1, n + 1);
        exp_q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.err     = err;
    e.code    = 0;
    exp_q.push_back(e);
  endtask

  // Called just after a falling edge; start is sampled on the next rising edge.
  task automatic run_cell(input int n, input int stall_req, input bit xs, input bit fs);
    bit err, sweeps, got;
    int l, k, s, j, pc, lat, lmax;
    err    = (n == (1 << W) - 1);
    sweeps = (n > 0) && !err;
    push_model(n);
    if (!sweeps) begin
      l = 0;
    end else if (stall_req >= 0) begin
      l = stall_req;
    end else begin
      lmax = (2 * n * n - 1 < 4) ? 2 * n * n - 1 : 4;
      l    = int'($urandom_range(0, lmax));
    end
    k   = (l > 0) ? int'($urandom_range(6, 5 + 2 * n * n - l)) : 0;
    s   = sweeps ? int'($urandom_range(6, 4 + 2 * n * n)) : 6;
    lat = 9 + (sweeps ? 2 * n * n : 0) + l;

    bus.start              = 1'b1;
    bus.ref_particle_count = W'(n);
    j  = 0;
    pc = 0;
    got = 1'b0;
    while (!got && j < lat + 50) begin
      @(negedge clk);
      j++;
      bus.start = xs && (j == s);
      bus.stall = (l > 0) && (j >= k) && (j < k + l);
      if (j == 7) bus.ref_particle_count = W'($urandom);
      if (bus.pause_reading) pc++;
      if (bus.done) got = 1'b1;
    end
    chk("done_seen", int'(got), 1);
    chk("done_latency", j, lat);
    chk("pause_cycles", pc, l);

    bus.stall = 1'b0;
    bus.start = fs;
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_after_done", int'(bus.busy), 0);
    chk("cfg_err_sticky", int'(bus.cfg_err), int'(err));
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_reset(input int n);
    int j;
    push_model(n);
    bus.start              = 1'b1;
    bus.ref_particle_count = W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    j = 1;
    while (bus.ref_id != W'(2) && j < 500) begin
      @(negedge clk);
      j++;
    end
    chk("reach_ref2", int'(bus.ref_id), 2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ids", int'({bus.ref_id, bus.particle_id}), 0);
    chk("async_rst_flags", int'({bus.phase, bus.reading_particle_num, bus.pause_reading,
                                 bus.busy, bus.done, bus.cfg_err}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start              = 1'b0;
    bus.stall              = 1'b0;
    bus.ref_particle_count = '0;
    repeat (3) @(negedge clk);
    chk("reset_ids", int'({bus.ref_id, bus.particle_id}), 0);
    chk("reset_flags", int'({bus.phase, bus.reading_particle_num, bus.pause_reading,
                             bus.busy, bus.done, bus.cfg_err}), 0);
    #1 rst = 1'b0;

    run_cell(3, 0, 1'b0, 1'b0);
    run_cell(0, 0, 1'b0, 1'b0);
    run_cell(2, 4, 1'b0, 1'b0);
    run_cell(127, 0, 1'b0, 1'b0);
    run_cell(3, 0, 1'b0, 1'b1);
    run_reset(5);
    run_cell(5, 0, 1'b0, 1'b0);
    run_cell(4, -1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_cell(int'($urandom_range(1, 6)), -1,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
